// File: rtl/cnt_seq_if.sv
// Handshake and operand bundle between the integer pipeline and the iterative
// count unit. The master side issues requests and the slave side returns counts.
interface cnt_seq_if #(
   parameter int WIDTH = 64
);
   logic                    start;
   logic                    flush;
   logic [1:0]              op;
   logic                    w;
   logic [WIDTH-1:0]        a;
   logic                    busy;
   logic                    done;
   logic [$clog2(WIDTH):0]  result;

   modport master (output start, flush, op, w, a, input busy, done, result);
   modport slave  (input start, flush, op, w, a, output busy, done, result);
endinterface

// File: rtl/cnt_seq.sv
// Iterative clz/ctz/cpop unit for the BMU. It consumes one CHUNK-bit slice of the
// operand per cycle, starting from the most significant slice.
module cnt_seq #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic     clk,
   input  logic     reset,
   cnt_seq_if.slave bus
);
   localparam int RW   = $clog2(WIDTH) + 1;
   localparam int NC   = WIDTH / CHUNK;
   localparam int KW   = $clog2(NC);
   localparam int HALF = WIDTH / 2;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t            state, state_d;
   logic [WIDTH-1:0]  e, e_init, a_rev;
   logic [RW-1:0]     acc, acc_nxt, lz, pop, result_q;
   logic [KW-1:0]     k;
   logic [CHUNK-1:0]  chunk;
   logic              cpop_q, w_q, found, found_nxt, last, finish, accept;

   // The operand is kept left-aligned and shifted up each cycle, so the slice
   // under inspection is always the top CHUNK bits.
   assign chunk = e[WIDTH-1 -: CHUNK];

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      lz  = RW'(CHUNK);
      pop = '0;
      for (int i = 0; i < CHUNK; i++) begin
         if (chunk[i]) lz = RW'(CHUNK - 1 - i);
         pop = pop + RW'(chunk[i]);
      end
   end

   assign acc_nxt   = acc + (cpop_q ? pop : lz);
   assign found_nxt = found | (!cpop_q && (|chunk));
   assign last      = w_q ? (k == KW'(NC / 2 - 1)) : (k == KW'(NC - 1));
   assign finish    = last || found_nxt;
   assign accept    = bus.start && !bus.flush && (state == IDLE || state == DONE);

   // ctz is clz of the bit-reversed operand; in word mode the top half of the
   // full reversal is already the reversed low word.
   always_comb begin
      a_rev  = '0;
      e_init = bus.a;
      for (int i = 0; i < WIDTH; i++) a_rev[i] = bus.a[WIDTH-1-i];
      if (bus.op == 2'b01)  e_init = a_rev;
      else if (bus.w)       e_init = {bus.a[HALF-1:0], {HALF{1'b0}}};
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_d;
   end

   always_comb begin
      state_d  = state;
      bus.busy = (state == RUN);
      bus.done = (state == DONE);
      if (bus.flush) begin
         state_d = IDLE;
      end else begin
         case (state)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (finish) state_d = DONE;
            DONE:    state_d = bus.start ? RUN : IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         e        <= '0;
         acc      <= '0;
         found    <= 1'b0;
         k        <= '0;
         cpop_q   <= 1'b0;
         w_q      <= 1'b0;
         result_q <= '0;
      end else if (accept) begin
         e      <= e_init;
         acc    <= '0;
         found  <= 1'b0;
         k      <= '0;
         cpop_q <= (bus.op == 2'b10);
         w_q    <= bus.w;
      end else if (state == RUN && !bus.flush) begin
         e     <= e << CHUNK;
         acc   <= acc_nxt;
         found <= found_nxt;
         k     <= k + KW'(1);
         if (finish) result_q <= acc_nxt;
      end
   end

   assign bus.result = result_q;
endmodule

// File: tb/tb_cnt_seq.sv
// Self-checking bench for cnt_seq: directed vector table, hand-written flush,
// restart and reset sequences, then random operations against a counting model.
module tb_cnt_seq;
   localparam int WIDTH = 64;
   localparam int CHUNK = 16;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   cnt_seq_if #(.WIDTH(WIDTH)) bus ();

   cnt_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [1:0]  op;
      logic        w;
      logic [63:0] a;
      int          exp_res;
      int          exp_cyc;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Counts straight from the definition: scan the N-bit operand from the
   // relevant end. Done arrives one cycle after the chunk holding the first set bit.
   function automatic void model(input logic [1:0] op, input logic w, input logic [63:0] a,
                                 output int res, output int cyc);
      int  n;
      int  cnt;
      int  idx;
      bit  seen;
      n    = w ? WIDTH / 2 : WIDTH;
      cnt  = 0;
      seen = 1'b0;
      if (op == 2'b10) begin
         for (int i = 0; i < n; i++) cnt += int'(a[i]);
         cyc = n / CHUNK + 1;
      end else begin
         for (int j = 0; j < n; j++) begin
            idx = (op == 2'b01) ? j : n - 1 - j;
            if (!seen) begin
               if (a[idx]) seen = 1'b1;
               else        cnt++;
            end
         end
         cyc = (cnt == n) ? n / CHUNK + 1 : cnt / CHUNK + 2;
      end
      res = cnt;
   endfunction

   // Called at a negedge; issues Start for one cycle and returns at the negedge
   // of the Done cycle. cyc is the cycle index of Done counting the accept as 0.
   task automatic run_op(input logic [1:0] op, input logic w, input logic [63:0] a,
                         output int res, output int cyc, output bit busy_ok);
      bus.start = 1'b1;
      bus.op    = op;
      bus.w     = w;
      bus.a     = a;
      @(negedge clk);
      bus.start = 1'b0;
      cyc       = 1;
      busy_ok   = 1'b1;
      while (bus.done !== 1'b1 && cyc < 100) begin
         if (bus.busy !== 1'b1) busy_ok = 1'b0;
         @(negedge clk);
         cyc++;
      end
      res = int'(bus.result);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not terminate");
      $fatal(1);
   end

   initial begin
      int res, cyc, exp_res, exp_cyc;
      bit busy_ok, seen_done, seen_busy;

      vecs[0]  = '{2'b00, 1'b0, 64'h0000_0000_0001_0000, 47, 4};
      vecs[1]  = '{2'b00, 1'b0, 64'h0000_0000_0000_0000, 64, 5};
      vecs[2]  = '{2'b01, 1'b0, 64'h8000_0000_0000_0000, 63, 5};
      vecs[3]  = '{2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64, 5};
      vecs[4]  = '{2'b10, 1'b0, 64'h0F0F_0000_0000_0001,  9, 5};
      vecs[5]  = '{2'b00, 1'b1, 64'hFFFF_FFFF_0000_0001, 31, 3};
      vecs[6]  = '{2'b01, 1'b1, 64'hFFFF_FFFF_0000_0000, 32, 3};
      vecs[7]  = '{2'b10, 1'b1, 64'hFFFF_FFFF_0000_00FF,  8, 3};
      vecs[8]  = '{2'b11, 1'b0, 64'h00F0_0000_0000_0000,  8, 2};
      vecs[9]  = '{2'b01, 1'b0, 64'h0000_0000_0000_0001,  0, 2};
      vecs[10] = '{2'b00, 1'b1, 64'h0000_0000_0000_0000, 32, 3};

      reset     = 1'b1;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      bus.op    = 2'b00;
      bus.w     = 1'b0;
      bus.a     = '0;
      repeat (2) @(negedge clk);
      check("reset busy", bus.busy, 0);
      check("reset done", bus.done, 0);
      check("reset result", bus.result, 0);
      reset = 1'b0;

      // Directed vectors
      foreach (vecs[i]) begin
         @(negedge clk);
         run_op(vecs[i].op, vecs[i].w, vecs[i].a, res, cyc, busy_ok);
         check($sformatf("vec%0d result", i), res, vecs[i].exp_res);
         check($sformatf("vec%0d done cycle", i), cyc, vecs[i].exp_cyc);
         check($sformatf("vec%0d busy", i), busy_ok, 1);
      end

      // Flush mid-run: no Done, Result holds the prior count
      @(negedge clk);
      run_op(2'b10, 1'b0, 64'h3, res, cyc, busy_ok);
      check("pre-flush result", res, 2);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = 2'b00;
      bus.a     = '0;
      @(negedge clk);
      bus.start = 1'b0;
      check("flush run busy", bus.busy, 1);
      @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      check("flush busy", bus.busy, 0);
      check("flush done", bus.done, 0);
      check("flush result held", bus.result, 2);
      seen_done = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (bus.done) seen_done = 1'b1;
      end
      check("flush no done pulse", seen_done, 0);

      // Start together with Flush from IDLE is dropped
      bus.start = 1'b1;
      bus.flush = 1'b1;
      bus.op    = 2'b10;
      bus.a     = '1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.flush = 1'b0;
      seen_done = 1'b0;
      seen_busy = 1'b0;
      repeat (6) begin
         if (bus.busy) seen_busy = 1'b1;
         if (bus.done) seen_done = 1'b1;
         @(negedge clk);
      end
      check("start+flush busy", seen_busy, 0);
      check("start+flush done", seen_done, 0);
      check("start+flush result", bus.result, 2);

      // Start during RUN is ignored; then back-to-back restart from DONE
      bus.start = 1'b1;
      bus.op    = 2'b10;
      bus.w     = 1'b0;
      bus.a     = 64'h00FF_00FF_0000_000F;
      @(negedge clk);
      repeat (3) begin
         bus.start = 1'b1;
         bus.op    = 2'b00;
         bus.a     = {$urandom, $urandom};
         @(negedge clk);
      end
      bus.start = 1'b0;
      check("ignore start busy c4", bus.busy, 1);
      check("ignore start done c4", bus.done, 0);
      @(negedge clk);
      check("ignore start done c5", bus.done, 1);
      check("ignore start result", bus.result, 20);
      run_op(2'b00, 1'b0, 64'h0000_0001_0000_0000, res, cyc, busy_ok);
      check("back-to-back result", res, 31);
      check("back-to-back done cycle", cyc, 3);

      // Reset in the middle of a cpop
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = 2'b10;
      bus.a     = '1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mid reset busy", bus.busy, 0);
      check("mid reset done", bus.done, 0);
      check("mid reset result", bus.result, 0);
      run_op(2'b00, 1'b0, 64'h0000_0000_0001_0000, res, cyc, busy_ok);
      check("post-reset result", res, 47);
      check("post-reset done cycle", cyc, 4);

      // Random operations, sometimes back-to-back
      for (int t = 0; t < 150; t++) begin
         logic [1:0]  r_op;
         logic        r_w;
         logic [63:0] r_a;
         r_op = 2'($urandom_range(0, 3));
         r_w  = 1'($urandom_range(0, 1));
         r_a  = {$urandom, $urandom} >> $urandom_range(0, 63);
         if ($urandom_range(0, 1) == 0) r_a = r_a | ({$urandom, $urandom} << 32);
         if ($urandom_range(0, 2) != 0) @(negedge clk);
         model(r_op, r_w, r_a, exp_res, exp_cyc);
         run_op(r_op, r_w, r_a, res, cyc, busy_ok);
         check($sformatf("rand%0d op%0d w%0d a=%h result", t, r_op, r_w, r_a), res, exp_res);
         check($sformatf("rand%0d done cycle", t), cyc, exp_cyc);
      end

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
